// File: rtl/amstrad_crtc.sv
// ----------------------------------------------------------------------------
// amstrad_crtc
// UM6845R-compatible (CRTC type 1) timing generator for the CPC Gate Array.
// Generates horizontal/vertical sync, display enable and the MA/RA video
// address from the programmable register file R0..R17.
//
// Ports
//   CLK     in   1  system clock
//   RESET   in   1  synchronous, active-high reset
//   CE      in   1  character clock enable; all counters advance on CLK & CE
//   IDX_WE  in   1  latch D[4:0] as the register index (&BCxx)
//   DAT_WE  in   1  write D to the indexed register (&BDxx)
//   D       in   8  CPU write data
//   Q       out  8  read data for the indexed register (&BFxx, combinational)
//   HSYNC   out  1  horizontal sync
//   VSYNC   out  1  vertical sync
//   DE      out  1  display enable
//   MA      out 14  memory address
//   RA      out  5  raster address within the character row
// ----------------------------------------------------------------------------
module amstrad_crtc (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        IDX_WE,
    input  logic        DAT_WE,
    input  logic [7:0]  D,
    output logic [7:0]  Q,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DE,
    output logic [13:0] MA,
    output logic [4:0]  RA
);

    // Register file, each register stored at its implemented width.
    logic [4:0] r_idx;
    logic [7:0] r_r0, r_r1, r_r2, r_r3, r_r13, r_r15;
    logic [6:0] r_r4, r_r6, r_r7, r_r10;
    logic [4:0] r_r5, r_r9, r_r11;
    logic [1:0] r_r8;
    logic [5:0] r_r12, r_r14;

    // Timing state.
    logic [7:0]  r_hcc;
    logic [4:0]  r_ra;
    logic [6:0]  r_vcc;
    logic        r_adjust;
    logic        r_vdisp;
    logic [3:0]  r_hs_cnt;
    logic [4:0]  r_vs_cnt;
    logic [13:0] r_ma_row;

    // Cursor, interlace and the sync-width high nibble have no effect on a type 1 timing chain.
    logic w_unused;
    assign w_unused = ^{r_r3[7:4], r_r8, r_r10, r_r11};

    // NOTE: the register file is a handful of flops rather than a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_idx <= '0;
            r_r0  <= '0; r_r1  <= '0; r_r2  <= '0; r_r3  <= '0;
            r_r4  <= '0; r_r5  <= '0; r_r6  <= '0; r_r7  <= '0;
            r_r8  <= '0; r_r9  <= '0; r_r10 <= '0; r_r11 <= '0;
            r_r12 <= '0; r_r13 <= '0; r_r14 <= '0; r_r15 <= '0;
        end else begin
            if (IDX_WE)
                r_idx <= D[4:0];
            if (DAT_WE) begin
                case (r_idx)
                    5'd0:  r_r0  <= D;
                    5'd1:  r_r1  <= D;
                    5'd2:  r_r2  <= D;
                    5'd3:  r_r3  <= D;
                    5'd4:  r_r4  <= D[6:0];
                    5'd5:  r_r5  <= D[4:0];
                    5'd6:  r_r6  <= D[6:0];
                    5'd7:  r_r7  <= D[6:0];
                    5'd8:  r_r8  <= D[1:0];
                    5'd9:  r_r9  <= D[4:0];
                    5'd10: r_r10 <= D[6:0];
                    5'd11: r_r11 <= D[4:0];
                    5'd12: r_r12 <= D[5:0];
                    5'd13: r_r13 <= D;
                    5'd14: r_r14 <= D[5:0];
                    5'd15: r_r15 <= D;
                    default: ; // R16/R17 (no light pen) and indices above 17 store nothing
                endcase
            end
        end
    end

    // Type 1 reads back only the cursor address; everything else reads 0.
    always_comb begin
        Q = '0;
        case (r_idx)
            5'd14:   Q = {2'b00, r_r14};
            5'd15:   Q = r_r15;
            default: ;
        endcase
    end

    // Event decode from the current counter values.
    logic       w_line_end, w_row_end, w_frame_end, w_adj_end;
    logic       w_new_frame, w_enter_adj, w_next_row, w_row_start;
    logic [7:0] w_hcc_n;
    logic [6:0] w_vcc_inc;
    logic [3:0] w_hs_dec;
    logic [4:0] w_vs_dec;

    // Counters compare for equality only, so a register written below the
    // current count lets the counter run on to its natural wrap.
    assign w_line_end  = (r_hcc == r_r0);
    assign w_hcc_n     = w_line_end ? 8'd0 : r_hcc + 8'd1;
    assign w_row_end   = w_line_end & ~r_adjust & (r_ra == r_r9);
    assign w_frame_end = w_row_end & (r_vcc == r_r4);
    assign w_adj_end   = w_line_end & r_adjust & (r_ra == r_r5 - 5'd1);
    assign w_new_frame = (w_frame_end & (r_r5 == 5'd0)) | w_adj_end;
    assign w_enter_adj = w_frame_end & (r_r5 != 5'd0);
    assign w_next_row  = w_row_end & ~w_frame_end;
    assign w_row_start = w_next_row | w_new_frame;
    assign w_vcc_inc   = r_vcc + 7'd1;
    assign w_hs_dec    = (r_hs_cnt != 4'd0) ? r_hs_cnt - 4'd1 : 4'd0;
    // VSYNC width is measured in lines, so it only counts down on line ends.
    assign w_vs_dec    = (w_line_end && r_vs_cnt != 5'd0) ? r_vs_cnt - 5'd1 : r_vs_cnt;

    logic [4:0]  w_ra_n;
    logic [6:0]  w_vcc_n;
    logic        w_adjust_n, w_vdisp_n;
    logic [13:0] w_ma_row_n;
    logic [3:0]  w_hs_n;
    logic [4:0]  w_vs_n;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_ra_n     = r_ra;
        w_vcc_n    = r_vcc;
        w_adjust_n = r_adjust;
        w_vdisp_n  = r_vdisp;
        w_ma_row_n = r_ma_row;

        if (w_line_end)
            w_ra_n = r_ra + 5'd1;
        // The line that closes a character row (including the last row before adjust) advances the row address.
        if (w_row_end)
            w_ma_row_n = r_ma_row + {6'd0, r_r1};
        if (w_next_row) begin
            w_ra_n  = 5'd0;
            w_vcc_n = w_vcc_inc;
            if (w_vcc_inc == r_r6)
                w_vdisp_n = 1'b0;
        end
        if (w_enter_adj) begin
            w_ra_n     = 5'd0;
            w_adjust_n = 1'b1;
        end
        if (w_new_frame) begin
            w_ra_n     = 5'd0;
            w_vcc_n    = 7'd0;
            w_adjust_n = 1'b0;
            w_ma_row_n = {r_r12, r_r13};
            w_vdisp_n  = (r_r6 != 7'd0);
        end

        // Sync pulses only (re)start once the previous pulse has run out.
        w_hs_n = w_hs_dec;
        if (w_hcc_n == r_r2 && w_hs_dec == 4'd0)
            w_hs_n = r_r3[3:0];
        w_vs_n = w_vs_dec;
        if (w_row_start && w_vcc_n == r_r7 && w_vs_dec == 5'd0)
            w_vs_n = 5'd16;
    end

    // Outputs are registered from the next-state values so they line up with the counters on the same CE.
    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hcc    <= '0;
            r_ra     <= '0;
            r_vcc    <= '0;
            r_adjust <= 1'b0;
            r_vdisp  <= 1'b0;
            r_hs_cnt <= '0;
            r_vs_cnt <= '0;
            r_ma_row <= '0;
            HSYNC    <= 1'b0;
            VSYNC    <= 1'b0;
            DE       <= 1'b0;
            MA       <= '0;
            RA       <= '0;
        end else if (CE) begin
            r_hcc    <= w_hcc_n;
            r_ra     <= w_ra_n;
            r_vcc    <= w_vcc_n;
            r_adjust <= w_adjust_n;
            r_vdisp  <= w_vdisp_n;
            r_hs_cnt <= w_hs_n;
            r_vs_cnt <= w_vs_n;
            r_ma_row <= w_ma_row_n;
            HSYNC    <= (w_hs_n != 4'd0);
            VSYNC    <= (w_vs_n != 5'd0);
            DE       <= (w_hcc_n < r_r1) & w_vdisp_n & ~w_adjust_n;
            MA       <= w_ma_row_n + {6'd0, w_hcc_n};
            RA       <= w_ra_n;
        end
    end

endmodule

// File: tb/tb_amstrad_crtc.sv
// ----------------------------------------------------------------------------
// tb_amstrad_crtc
// Self-checking bench for amstrad_crtc. A reference model tracks the beam
// position as (line within frame, character within line) and derives every
// output from the frame geometry implied by the register values.
// ----------------------------------------------------------------------------
module tb_amstrad_crtc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        CE = 1'b0;
    logic        IDX_WE = 1'b0;
    logic        DAT_WE = 1'b0;
    logic [7:0]  D = 8'd0;
    logic [7:0]  Q;
    logic        HSYNC, VSYNC, DE;
    logic [13:0] MA;
    logic [4:0]  RA;

    amstrad_crtc dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .CE     (CE),
        .IDX_WE (IDX_WE),
        .DAT_WE (DAT_WE),
        .D      (D),
        .Q      (Q),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .DE     (DE),
        .MA     (MA),
        .RA     (RA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model copy of R0..R15 at their implemented widths.
    int r[16];
    int reg_w[16] = '{8, 8, 8, 8, 7, 5, 7, 7, 2, 5, 7, 5, 6, 8, 6, 8};
    int pos_l, pos_h, frame;

    function automatic int total_lines();
        return (r[4] + 1) * (r[9] + 1) + r[5];
    endfunction

    // Expected {HSYNC, VSYNC, DE, MA, RA} at line l, character h of a frame.
    function automatic logic [21:0] expect_out(input int l, input int h);
        int rh, main_l, vcc, ra, row, len, w, vs_l, d;
        bit adj, hs, vs, de;
        logic [13:0] ma;
        rh     = r[9] + 1;
        main_l = (r[4] + 1) * rh;
        adj    = (l >= main_l);
        vcc    = adj ? r[4] : l / rh;
        ra     = adj ? l - main_l : l % rh;
        row    = adj ? r[4] + 1 : vcc;
        ma     = 14'((r[12] * 256 + r[13] + row * r[1] + h) % 16384);
        de     = !adj && (h < r[1]) && (vcc < r[6]);
        len    = r[0] + 1;
        w      = r[3] & 15;
        hs     = (w != 0) && (r[2] <= r[0]) && (((h - r[2] + len) % len) < w);
        vs     = 1'b0;
        if (r[7] <= r[4]) begin
            vs_l = r[7] * rh;
            d    = (l - vs_l + total_lines()) % total_lines();
            vs   = (d < 16);
        end
        return {hs, vs, de, ma, 5'(ra)};
    endfunction

    task automatic set_idx(input logic [7:0] d);
        @(negedge CLK); IDX_WE = 1'b1; D = d;
        @(negedge CLK); IDX_WE = 1'b0; D = 8'd0;
    endtask

    task automatic write_reg(input int idx, input int val);
        set_idx(8'(idx));
        @(negedge CLK); DAT_WE = 1'b1; D = 8'(val);
        @(negedge CLK); DAT_WE = 1'b0; D = 8'd0;
        if (idx < 16)
            r[idx] = val & ((1 << reg_w[idx]) - 1);
    endtask

    task automatic do_reset();
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        for (int i = 0; i < 16; i++) r[i] = 0;
        pos_l = 0; pos_h = 0; frame = 0;
    endtask

    // One character clock; from frame 1 on every output is compared to the model.
    task automatic ce_step(input int idle);
        repeat (idle) @(negedge CLK);
        @(negedge CLK); CE = 1'b1;
        @(posedge CLK); #1; CE = 1'b0;
        if (pos_h == r[0]) begin
            pos_h = 0;
            pos_l++;
            if (pos_l == total_lines()) begin
                pos_l = 0;
                frame++;
            end
        end else begin
            pos_h++;
        end
        if (frame >= 1)
            check($sformatf("out f%0d l%0d h%0d", frame, pos_l, pos_h),
                  {HSYNC, VSYNC, DE, MA, RA}, expect_out(pos_l, pos_h));
    endtask

    int hs_line, de_line, hs_seen;
    int c0, c1, c2, c3, c4, c5, c6, c7, c9, c12, c13, w;

    initial begin
        // ---------------- CPC default timing ----------------
        do_reset();
        check("rst_out", {HSYNC, VSYNC, DE, MA, RA}, 0);
        check("rst_q", Q, 0);
        write_reg(0, 63);  write_reg(1, 40);  write_reg(2, 46);  write_reg(3, 8'h8E);
        write_reg(4, 38);  write_reg(5, 0);   write_reg(6, 25);  write_reg(7, 30);
        write_reg(9, 7);   write_reg(12, 8'h30); write_reg(13, 0);
        write_reg(14, 8'h2A); write_reg(15, 8'hC3);
        hs_line = 0; de_line = 0;
        while (!(frame == 2 && pos_l == 100 && pos_h == 20)) begin
            ce_step(0);
            if (frame == 1) begin
                if (pos_h == 0) begin hs_line = 0; de_line = 0; end
                hs_line += int'(HSYNC);
                de_line += int'(DE);
                if (pos_l == 0 && pos_h == 0) begin
                    check("a_ma_start", MA, 14'h3000);
                    check("a_de_first", DE, 1);
                    check("a_ra_first", RA, 0);
                end
                if (pos_l == 8 && pos_h == 0)    check("a_ma_l8", MA, 14'h3028);
                if (pos_l == 199 && pos_h == 39) check("a_ma_l199", MA, 14'h33E7);
                if (pos_l == 1 && pos_h == 63) begin
                    check("a_hs_width", hs_line, 14);
                    check("a_de_width", de_line, 40);
                end
                if (pos_l == 200 && pos_h == 63) check("a_de_blank", de_line, 0);
                if (pos_h == 0 && (pos_l == 239 || pos_l == 240 || pos_l == 255 || pos_l == 256))
                    check($sformatf("a_vs_l%0d", pos_l), VSYNC, (pos_l >= 240 && pos_l <= 255));
                // Add two adjust lines to this frame.
                if (pos_l == 260 && pos_h == 0) write_reg(5, 2);
                if (pos_l >= 312 && pos_h == 0) begin
                    check($sformatf("a_adj_ra_l%0d", pos_l), RA, pos_l - 312);
                    check("a_adj_de", DE, 0);
                end
            end
            if (frame == 2 && pos_l == 0 && pos_h == 0) check("a_ma_f2", MA, 14'h3000);
        end

        // ---------------- Reset mid-frame ----------------
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        check("rst_mid_out", {HSYNC, VSYNC, DE, MA, RA}, 0);
        @(negedge CLK); RESET = 1'b0;
        set_idx(8'd14); check("rst_mid_r14", Q, 0);
        set_idx(8'd15); check("rst_mid_r15", Q, 0);

        // ---------------- Register access ----------------
        set_idx(8'hEE);                       // only D[4:0] selects: index 14
        @(negedge CLK); DAT_WE = 1'b1; D = 8'hFF;
        @(negedge CLK); DAT_WE = 1'b0; D = 8'd0;
        check("q_r14", Q, 8'h3F);
        write_reg(15, 8'hA5); check("q_r15", Q, 8'hA5);
        write_reg(31, 8'h55);
        set_idx(8'd15);       check("q_r15_keep", Q, 8'hA5);
        write_reg(12, 8'h3F); check("q_r12", Q, 0);
        set_idx(8'd16);       check("q_r16", Q, 0);

        // ---------------- Randomized geometries ----------------
        for (int k = 0; k < 8; k++) begin
            do_reset();
            c0 = 7 + int'($urandom % 17);
            c1 = int'($urandom % (c0 + 3));
            c2 = int'($urandom % (c0 + 2));
            w  = int'($urandom % 16);
            if (w > c0 + 1) w = c0 + 1;
            c3 = (int'($urandom % 16) << 4) | w;
            if (k == 0) c3 = 8'h80;
            c4 = 2 + int'($urandom % 8);
            c9 = int'($urandom % 4);
            c5 = int'($urandom % 8);
            if ((c4 + 1) * (c9 + 1) + c5 < 20) begin c4 = 9; c9 = 3; end
            c6  = int'($urandom % (c4 + 3));
            c7  = int'($urandom % (c4 + 3));
            c12 = int'($urandom % 256);
            c13 = int'($urandom % 256);
            write_reg(0, c0); write_reg(1, c1); write_reg(2, c2);  write_reg(3, c3);
            write_reg(4, c4); write_reg(5, c5); write_reg(6, c6);  write_reg(7, c7);
            write_reg(9, c9); write_reg(12, c12); write_reg(13, c13);
            hs_seen = 0;
            while (frame < 2) begin
                ce_step(int'($urandom % 2));
                hs_seen += int'(HSYNC);
            end
            if (k == 0) check("b_no_hs", hs_seen, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
